// File: rtl/arcade_input_mapper.sv
// Maps PS/2 keyboard events and two joysticks onto arcade player controls, with
// rotation, opposing-direction cancellation, shaped coin pulses and autofire.
module arcade_input_mapper #(
    parameter int          NPLAYERS     = 2,
    parameter logic [15:0] COIN_CYCLES  = 16'd50000,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic [1:0]  rotate,
    input  logic        autofire_en,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic [2:0]  p1_btn,
    output logic [2:0]  p2_btn,
    output logic [1:0]  start,
    output logic [1:0]  coin
);

    localparam logic [15:0] COIN_LAST = COIN_CYCLES - 16'd1;
    localparam logic [19:0] AF_LAST   = AUTOFIRE_DIV - 20'd1;
    // Key-state bits kept for player 1 only when a single player is configured.
    localparam logic [17:0] P1_ONLY_MASK = 18'b010100000001111111;

    typedef enum logic [1:0] {
        COIN_IDLE    = 2'd0,
        COIN_ACTIVE  = 2'd1,
        COIN_LOCKOUT = 2'd2
    } coin_state_e;

    logic        toggle_q, toggle_d;
    logic        primed_q, primed_d;
    // [3:0] P1 {U,D,L,R}, [6:4] P1 {b2,b1,b0}, [10:7] P2 dir, [13:11] P2 btn,
    // [15:14] {start2,start1}, [17:16] {coin2,coin1}
    logic [17:0] keys_q, keys_d;
    logic [19:0] af_cnt_q, af_cnt_d;
    logic        af_phase_q, af_phase_d;
    coin_state_e coin_state_q [2];
    coin_state_e coin_state_d [2];
    logic [15:0] coin_cnt_q [2];
    logic [15:0] coin_cnt_d [2];
    logic [1:0]  coin_prev_q, coin_prev_d;
    logic [1:0]  coin_q, coin_d;
    logic [3:0]  p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
    logic [2:0]  p1_btn_q, p1_btn_d, p2_btn_q, p2_btn_d;
    logic [1:0]  start_q, start_d;

    logic        pressed_s, extended_s, key_event_s, af_gate_s;
    logic [8:0]  code_s;
    logic [15:0] joy1_s, joy2_s;
    logic [17:0] keys_eff_s;
    logic [3:0]  raw1_dir_s, raw2_dir_s;
    logic [2:0]  raw1_btn_s, raw2_btn_s;
    logic [1:0]  raw_start_s, raw_coin_s;
    logic        unused_ok_s;

    assign unused_ok_s = ^{joystick_0[15:9], joystick_1[15:9]};

    // Rotate a {U,D,L,R} vector, then cancel simultaneous opposing directions.
    function automatic logic [3:0] shape_dir(input logic [3:0] raw, input logic [1:0] rot);
        logic [3:0] r;
        case (rot)
            2'd1:    r = {raw[1], raw[0], raw[2], raw[3]};
            2'd2:    r = {raw[0], raw[1], raw[3], raw[2]};
            default: r = raw;
        endcase
        if (r[3] && r[2]) begin
            r[3:2] = 2'b00;
        end else begin
            r[3:2] = r[3:2];
        end
        if (r[1] && r[0]) begin
            r[1:0] = 2'b00;
        end else begin
            r[1:0] = r[1:0];
        end
        return r;
    endfunction

    // PS/2 event detection and key-state update.
    always_comb begin
        pressed_s   = (ps2_key[15:8] != 8'hF0);
        extended_s  = pressed_s ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        code_s      = (ps2_key[63:24] != 40'd0) ? 9'd0 : {extended_s, ps2_key[7:0]};
        key_event_s = primed_q & (ps2_key[64] != toggle_q);
        toggle_d    = ps2_key[64];
        primed_d    = 1'b1;
        keys_d      = keys_q;
        if (key_event_s) begin
            case (code_s)
                9'h175:         keys_d[3]  = pressed_s;
                9'h172:         keys_d[2]  = pressed_s;
                9'h16B:         keys_d[1]  = pressed_s;
                9'h174:         keys_d[0]  = pressed_s;
                9'h014, 9'h114: keys_d[4]  = pressed_s;
                9'h011, 9'h111: keys_d[5]  = pressed_s;
                9'h029, 9'h129: keys_d[6]  = pressed_s;
                9'h02D, 9'h12D: keys_d[10] = pressed_s;
                9'h02B, 9'h12B: keys_d[9]  = pressed_s;
                9'h023, 9'h123: keys_d[8]  = pressed_s;
                9'h034, 9'h134: keys_d[7]  = pressed_s;
                9'h01C, 9'h11C: keys_d[11] = pressed_s;
                9'h01B, 9'h11B: keys_d[12] = pressed_s;
                9'h015, 9'h115: keys_d[13] = pressed_s;
                9'h005, 9'h105: keys_d[14] = pressed_s;
                9'h006, 9'h106: keys_d[15] = pressed_s;
                9'h004, 9'h104: keys_d[16] = pressed_s;
                9'h00C, 9'h10C: keys_d[17] = pressed_s;
                default:        keys_d     = keys_q;
            endcase
        end else begin
            keys_d = keys_q;
        end
    end

    // Merge keys with joysticks and compute the next registered outputs.
    always_comb begin
        if (NPLAYERS == 1) begin
            joy1_s     = joystick_0 | joystick_1;
            joy2_s     = 16'h0000;
            keys_eff_s = keys_q & P1_ONLY_MASK;
        end else begin
            joy1_s     = joystick_0;
            joy2_s     = joystick_1;
            keys_eff_s = keys_q;
        end
        raw1_dir_s  = keys_eff_s[3:0]   | joy1_s[3:0];
        raw1_btn_s  = keys_eff_s[6:4]   | joy1_s[6:4];
        raw2_dir_s  = keys_eff_s[10:7]  | joy2_s[3:0];
        raw2_btn_s  = keys_eff_s[13:11] | joy2_s[6:4];
        raw_start_s = keys_eff_s[15:14] | {joy2_s[7], joy1_s[7]};
        raw_coin_s  = keys_eff_s[17:16] | {joy2_s[8], joy1_s[8]};
        af_gate_s   = af_phase_q | ~autofire_en;
        p1_dir_d    = shape_dir(raw1_dir_s, rotate);
        p2_dir_d    = shape_dir(raw2_dir_s, rotate);
        p1_btn_d    = {raw1_btn_s[2:1], raw1_btn_s[0] & af_gate_s};
        p2_btn_d    = {raw2_btn_s[2:1], raw2_btn_s[0] & af_gate_s};
        start_d     = raw_start_s;
    end

    // Free-running autofire divider; phase flips each time the counter wraps.
    always_comb begin
        if (af_cnt_q == AF_LAST) begin
            af_cnt_d   = 20'd0;
            af_phase_d = ~af_phase_q;
        end else begin
            af_cnt_d   = af_cnt_q + 20'd1;
            af_phase_d = af_phase_q;
        end
    end

    // Per-channel coin shaper: one fixed-width pulse, then an equal lockout.
    always_comb begin
        coin_prev_d = raw_coin_s;
        coin_d      = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            coin_state_d[ch] = coin_state_q[ch];
            coin_cnt_d[ch]   = coin_cnt_q[ch];
            case (coin_state_q[ch])
                COIN_IDLE: begin
                    coin_cnt_d[ch] = 16'd0;
                    if (raw_coin_s[ch] && !coin_prev_q[ch]) begin
                        coin_state_d[ch] = COIN_ACTIVE;
                        coin_d[ch]       = 1'b1;
                    end else begin
                        coin_state_d[ch] = COIN_IDLE;
                    end
                end
                COIN_ACTIVE: begin
                    if (coin_cnt_q[ch] == COIN_LAST) begin
                        coin_state_d[ch] = COIN_LOCKOUT;
                        coin_cnt_d[ch]   = 16'd0;
                    end else begin
                        coin_cnt_d[ch] = coin_cnt_q[ch] + 16'd1;
                        coin_d[ch]     = 1'b1;
                    end
                end
                COIN_LOCKOUT: begin
                    if (coin_cnt_q[ch] == COIN_LAST) begin
                        coin_state_d[ch] = COIN_IDLE;
                        coin_cnt_d[ch]   = 16'd0;
                    end else begin
                        coin_cnt_d[ch] = coin_cnt_q[ch] + 16'd1;
                    end
                end
                default: begin
                    coin_state_d[ch] = COIN_IDLE;
                    coin_cnt_d[ch]   = 16'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q    <= 1'b0;
            primed_q    <= 1'b0;
            keys_q      <= 18'd0;
            af_cnt_q    <= 20'd0;
            af_phase_q  <= 1'b1;
            coin_prev_q <= 2'b00;
            coin_q      <= 2'b00;
            p1_dir_q    <= 4'd0;
            p2_dir_q    <= 4'd0;
            p1_btn_q    <= 3'd0;
            p2_btn_q    <= 3'd0;
            start_q     <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                coin_state_q[ch] <= COIN_IDLE;
                coin_cnt_q[ch]   <= 16'd0;
            end
        end else begin
            toggle_q    <= toggle_d;
            primed_q    <= primed_d;
            keys_q      <= keys_d;
            af_cnt_q    <= af_cnt_d;
            af_phase_q  <= af_phase_d;
            coin_prev_q <= coin_prev_d;
            coin_q      <= coin_d;
            p1_dir_q    <= p1_dir_d;
            p2_dir_q    <= p2_dir_d;
            p1_btn_q    <= p1_btn_d;
            p2_btn_q    <= p2_btn_d;
            start_q     <= start_d;
            for (int ch = 0; ch < 2; ch++) begin
                coin_state_q[ch] <= coin_state_d[ch];
                coin_cnt_q[ch]   <= coin_cnt_d[ch];
            end
        end
    end

    assign p1_dir = p1_dir_q;
    assign p2_dir = p2_dir_q;
    assign p1_btn = p1_btn_q;
    assign p2_btn = p2_btn_q;
    assign start  = start_q;
    assign coin   = coin_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomized bench for arcade_input_mapper: a two-player and a one-player instance
// are compared every cycle against a timestamp/map based reference model.
module tb_arcade_input_mapper;

    localparam int C = 6;
    localparam int D = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [64:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic [1:0]  rotate;
    logic        autofire_en;
    logic [3:0]  p1_dir [2];
    logic [3:0]  p2_dir [2];
    logic [2:0]  p1_btn [2];
    logic [2:0]  p2_btn [2];
    logic [1:0]  start [2];
    logic [1:0]  coin [2];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit   keys [0:511];
    bit   m_primed, m_tog;
    int   cyc;
    int   pstart [2][2];
    int   blocked [2][2];
    bit   prev_raw [2][2];
    logic [3:0] e_p1d [2];
    logic [3:0] e_p2d [2];
    logic [2:0] e_p1b [2];
    logic [2:0] e_p2b [2];
    logic [1:0] e_start [2];
    logic [1:0] e_coin [2];

    int hi, pulses;
    bit prev_c;

    arcade_input_mapper #(.NPLAYERS(2), .COIN_CYCLES(16'd6), .AUTOFIRE_DIV(20'd4)) u_dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
        .autofire_en(autofire_en), .p1_dir(p1_dir[0]), .p2_dir(p2_dir[0]),
        .p1_btn(p1_btn[0]), .p2_btn(p2_btn[0]), .start(start[0]), .coin(coin[0])
    );

    arcade_input_mapper #(.NPLAYERS(1), .COIN_CYCLES(16'd6), .AUTOFIRE_DIV(20'd4)) u_dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
        .autofire_en(autofire_en), .p1_dir(p1_dir[1]), .p2_dir(p2_dir[1]),
        .p1_btn(p1_btn[1]), .p2_btn(p2_btn[1]), .start(start[1]), .coin(coin[1])
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic logic [8:0] spec_code(input logic [64:0] k);
        logic pressed, ext;
        pressed = (k[15:8] != 8'hF0);
        ext     = pressed ? (k[15:8] == 8'hE0) : (k[23:16] == 8'hE0);
        if (k[63:24] != 40'd0) return 9'd0;
        return {ext, k[7:0]};
    endfunction

    // arrows keep their extended flag; every other key ignores it
    function automatic logic [8:0] key_slot(input logic [8:0] c);
        if (c[8] && (c[7:0] == 8'h75 || c[7:0] == 8'h72 || c[7:0] == 8'h6B || c[7:0] == 8'h74))
            return c;
        return {1'b0, c[7:0]};
    endfunction

    function automatic logic [3:0] exp_dir(input bit u, input bit d, input bit l, input bit r,
                                           input logic [1:0] rot);
        bit ou, od, ol, orr;
        case (rot)
            2'd1:    begin ou = l; od = r; ol = d; orr = u; end
            2'd2:    begin ou = r; od = l; ol = u; orr = d; end
            default: begin ou = u; od = d; ol = l; orr = r; end
        endcase
        if (ou && od) begin ou = 1'b0; od = 1'b0; end
        if (ol && orr) begin ol = 1'b0; orr = 1'b0; end
        return {ou, od, ol, orr};
    endfunction

    task automatic model_reset();
        foreach (keys[k]) keys[k] = 1'b0;
        m_primed = 1'b0;
        m_tog    = 1'b0;
        cyc      = 0;
        for (int i = 0; i < 2; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                pstart[i][ch]   = -1000;
                blocked[i][ch]  = 0;
                prev_raw[i][ch] = 1'b0;
            end
            e_p1d[i] = 4'd0; e_p2d[i] = 4'd0;
            e_p1b[i] = 3'd0; e_p2b[i] = 3'd0;
            e_start[i] = 2'd0; e_coin[i] = 2'd0;
        end
    endtask

    // One rising edge of the reference model, using the inputs the DUT sampled.
    task automatic model_edge();
        int n;
        bit phase, two;
        bit r [2];
        logic [15:0] j1, j2;
        logic [8:0] c;
        n = cyc;
        phase = ((n / D) % 2) == 0;
        for (int i = 0; i < 2; i++) begin
            two = (i == 0);
            j1 = two ? joystick_0 : (joystick_0 | joystick_1);
            j2 = two ? joystick_1 : 16'h0000;
            e_p1d[i] = exp_dir(keys[9'h175] | j1[3], keys[9'h172] | j1[2],
                               keys[9'h16B] | j1[1], keys[9'h174] | j1[0], rotate);
            e_p1b[i] = {keys[9'h029] | j1[6], keys[9'h011] | j1[5],
                        (keys[9'h014] | j1[4]) & (phase | !autofire_en)};
            if (two) begin
                e_p2d[i] = exp_dir(keys[9'h02D] | j2[3], keys[9'h02B] | j2[2],
                                   keys[9'h023] | j2[1], keys[9'h034] | j2[0], rotate);
                e_p2b[i] = {keys[9'h015] | j2[6], keys[9'h01B] | j2[5],
                            (keys[9'h01C] | j2[4]) & (phase | !autofire_en)};
            end else begin
                e_p2d[i] = 4'd0;
                e_p2b[i] = 3'd0;
            end
            e_start[i] = {two & (keys[9'h006] | j2[7]), keys[9'h005] | j1[7]};
            r[0] = keys[9'h004] | j1[8];
            r[1] = two & (keys[9'h00C] | j2[8]);
            for (int ch = 0; ch < 2; ch++) begin
                if (r[ch] && !prev_raw[i][ch] && n >= blocked[i][ch]) begin
                    pstart[i][ch]  = n;
                    blocked[i][ch] = n + 2 * C;
                end
                prev_raw[i][ch] = r[ch];
                e_coin[i][ch] = (n >= pstart[i][ch]) && (n < pstart[i][ch] + C);
            end
        end
        if (m_primed && (ps2_key[64] != m_tog)) begin
            c = spec_code(ps2_key);
            keys[key_slot(c)] = (ps2_key[15:8] != 8'hF0);
        end
        m_tog    = ps2_key[64];
        m_primed = 1'b1;
        cyc++;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("p1_dir[%0d]", i), 32'(p1_dir[i]), 32'(e_p1d[i]));
            check($sformatf("p2_dir[%0d]", i), 32'(p2_dir[i]), 32'(e_p2d[i]));
            check($sformatf("p1_btn[%0d]", i), 32'(p1_btn[i]), 32'(e_p1b[i]));
            check($sformatf("p2_btn[%0d]", i), 32'(p2_btn[i]), 32'(e_p2b[i]));
            check($sformatf("start[%0d]", i),  32'(start[i]),  32'(e_start[i]));
            check($sformatf("coin[%0d]", i),   32'(coin[i]),   32'(e_coin[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        @(negedge clk_sys);
        compare_all();
    endtask

    task automatic tick_coin();
        tick();
        if (coin[0][0]) hi++;
        if (coin[0][0] && !prev_c) pulses++;
        prev_c = coin[0][0];
    endtask

    task automatic send_key(input logic [63:0] bytes);
        ps2_key = {~ps2_key[64], bytes};
    endtask

    function automatic logic [15:0] pick_code(input int i);
        case (i)
            0: return 16'hE075;  1: return 16'hE072;  2: return 16'hE06B;  3: return 16'hE074;
            4: return 16'h0014;  5: return 16'hE014;  6: return 16'h0011;  7: return 16'h0029;
            8: return 16'h002D;  9: return 16'h002B; 10: return 16'h0023; 11: return 16'h0034;
           12: return 16'h001C; 13: return 16'h001B; 14: return 16'h0015; 15: return 16'h0005;
           16: return 16'h0006; 17: return 16'h0004; 18: return 16'h000C; 19: return 16'h0075;
            default: return 16'h0033;
        endcase
    endfunction

    function automatic logic [63:0] rand_ps2();
        logic [15:0] p;
        int sel;
        p   = pick_code(int'($urandom_range(0, 20)));
        sel = int'($urandom_range(0, 9));
        if (sel < 5) return {40'd0, 8'($urandom), p};
        if (sel < 9) begin
            if (p[15:8] == 8'hE0) return {40'd0, 8'hE0, 8'hF0, p[7:0]};
            return {40'd0, 8'($urandom), 8'hF0, p[7:0]};
        end
        return {40'($urandom) | 40'd1, 8'($urandom), p};
    endfunction

    function automatic logic [15:0] rand_joy();
        logic [15:0] v;
        v = 16'($urandom);
        v[8] = ($urandom_range(0, 5) == 0);
        return v;
    endfunction

    initial begin
        reset_n     = 1'b0;
        ps2_key     = {1'b1, 64'h0000_0000_0000_0005};
        joystick_0  = 16'h0000;
        joystick_1  = 16'h0000;
        rotate      = 2'd0;
        autofire_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_sys);
        compare_all();
        reset_n = 1'b1;

        // toggle already high at release with code 005: no start
        repeat (3) tick();
        check("prime_no_event", 32'(start[0]), 32'd0);

        // arrow up press / release, two-clock latency
        send_key(64'h0000_0000_0000_E075);
        tick();
        check("arrow_lat1", 32'(p1_dir[0]), 32'd0);
        tick();
        check("arrow_up", 32'(p1_dir[0]), 32'b1000);
        send_key(64'h0000_0000_00E0_F075);
        tick(); tick();
        check("arrow_rel", 32'(p1_dir[0]), 32'd0);

        // rotation
        joystick_0 = 16'h0008; rotate = 2'd1;
        tick();
        check("rot_cw", 32'(p1_dir[0]), 32'b0001);
        rotate = 2'd2;
        tick();
        check("rot_ccw", 32'(p1_dir[0]), 32'b0010);
        rotate = 2'd3;
        tick();
        check("rot_3", 32'(p1_dir[0]), 32'b1000);
        rotate = 2'd0; joystick_0 = 16'h0000;
        tick();

        // joystick_1 merging in single-player mode
        joystick_1 = 16'h0008;
        tick();
        check("np1_p1_dir", 32'(p1_dir[1]), 32'b1000);
        check("np1_p2_dir", 32'(p2_dir[1]), 32'd0);
        check("np2_p2_dir", 32'(p2_dir[0]), 32'b1000);
        joystick_1 = 16'h0000;
        tick();

        // key up + joystick down cancel
        send_key(64'h0000_0000_0000_E075);
        joystick_0 = 16'h0004;
        tick(); tick();
        check("socd_ud", 32'(p1_dir[0]), 32'd0);
        joystick_0 = 16'h0000;
        tick();
        check("socd_release", 32'(p1_dir[0]), 32'b1000);
        send_key(64'h0000_0000_00E0_F075);
        tick(); tick();

        // autofire
        autofire_en = 1'b1; joystick_0 = 16'h0010;
        hi = 0;
        repeat (16) begin
            tick();
            if (p1_btn[0][0]) hi++;
        end
        check("af_duty", 32'(hi), 32'd8);
        autofire_en = 1'b0;
        repeat (5) begin
            tick();
            check("af_off", 32'(p1_btn[0][0]), 32'd1);
        end
        joystick_0 = 16'h0000;
        tick();

        // coin held: one pulse of C clocks
        hi = 0; pulses = 0; prev_c = 1'b0;
        joystick_0 = 16'h0100;
        repeat (5 * C) tick_coin();
        check("coin_width", 32'(hi), 32'(C));
        check("coin_once", 32'(pulses), 32'd1);
        joystick_0 = 16'h0000;
        repeat (2 * C) tick_coin();

        // second press during lockout ignored
        hi = 0; pulses = 0;
        joystick_0 = 16'h0100;
        tick_coin();
        joystick_0 = 16'h0000;
        repeat (C + 1) tick_coin();
        joystick_0 = 16'h0100;
        tick_coin(); tick_coin();
        joystick_0 = 16'h0000;
        repeat (3 * C) tick_coin();
        check("coin_lockout", 32'(pulses), 32'd1);

        // reset in the middle of a coin pulse
        joystick_0 = 16'h0100;
        tick(); tick();
        check("coin_before_reset", 32'(coin[0][0]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_coin_drop", 32'(coin[0]), 32'd0);
        model_reset();
        joystick_0 = 16'h0000;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        hi = 0; pulses = 0; prev_c = 1'b0;
        repeat (3 * C) tick_coin();
        check("no_resume", 32'(hi), 32'd0);

        // randomized traffic
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 7) == 0) joystick_0 = rand_joy();
            if ($urandom_range(0, 7) == 0) joystick_1 = rand_joy();
            if ($urandom_range(0, 31) == 0) rotate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) autofire_en = ~autofire_en;
            if ($urandom_range(0, 3) == 0) send_key(rand_ps2());
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 SHALL have parameter NPLAYERS, default 2, number of players (1 or 2); with 1, joystick_0 and joystick_1 are ORed into player 1 and all P2 outputs are held 0.
REQ-002 SHALL have parameter COIN_CYCLES, default 16'd50000, coin output high time in clocks; also the lockout length.
REQ-003 SHALL have parameter AUTOFIRE_DIV, default 20'd400000, clocks per autofire phase.
REQ-004 clk_sys  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ps2_key  in  65  bit 64 = event toggle; [15:0] = scan code/prefix bytes; [63:24] nonzero = PRNSCR/PAUSE sequence.
REQ-007 joystick_0, joystick_1  in  16 each  bit0 R, 1 L, 2 D, 3 U, 4 btn0, 5 btn1, 6 btn2, 7 start, 8 coin; active-high.
REQ-008 rotate  in  2  0 none, 1 cw, 2 ccw, 3 treated as 0.
REQ-009 autofire_en  in  1  enables autofire on btn0 of both players.
REQ-010 p1_dir, p2_dir  out  4 each  {up,down,left,right}, active-high, registered.
REQ-011 p1_btn, p2_btn  out  3 each  {btn2,btn1,btn0}, registered.
REQ-012 start  out  2  {start2,start1}; coin  out  2  {coin2,coin1}, pulse-shaped.

Function
REQ-013 SHALL detect a key event when ps2_key[64] differs from its registered copy; the first clock after reset release SHALL only load the copy (no event).
REQ-014 pressed = (ps2_key[15:8] != F0); extended = pressed ? (ps2_key[15:8]==E0) : (ps2_key[23:16]==E0); code = {extended, ps2_key[7:0]}, forced 0 when [63:24] nonzero.
REQ-015 SHALL latch the key-state bit on the event edge: arrows (E0-75/72/6B/74) P1 U/D/L/R; 014 P1 btn0; 011 P1 btn1; 029 P1 btn2; 02D/02B/023/034 (R/F/D/G) P2 U/D/L/R; 01C/01B/015 (A/S/Q) P2 btn0/1/2; 005 start1; 006 start2; 004 coin1; 00C coin2. Extended bit ignored except for arrows; other codes no effect.
REQ-016 Raw per-player signals SHALL be OR of key state and the player's joystick bits.
REQ-017 Rotation after merge: rotate=1: U<-L, D<-R, L<-D, R<-U; rotate=2: U<-R, D<-L, L<-U, R<-D.
REQ-018 After rotation, U and D both raw-high SHALL output both 0; same for L and R.
REQ-019 Latency: joystick change to output 1 clock; ps2 toggle change to output 2 clocks; rotate change applies on next output update.
REQ-020 Coin FSM per channel: IDLE -> ACTIVE on raw rising edge (coin=1, count COIN_CYCLES clocks) -> LOCKOUT (coin=0, COIN_CYCLES clocks) -> IDLE; edges during ACTIVE/LOCKOUT ignored; held input yields one pulse only.
REQ-021 Autofire: one shared counter 0..AUTOFIRE_DIV-1 wrapping; phase toggles on wrap; btn0 out = raw btn0 & (phase | ~autofire_en); counter and phase run continuously.
REQ-022 start outputs SHALL be unshaped level, same latency as buttons.

Reset
REQ-023 reset_n low SHALL asynchronously clear all outputs, key-state bits, coin FSMs to IDLE with counters 0, autofire counter 0, phase 1, toggle copy 0, primed flag 0.
REQ-024 Reset asserted mid coin pulse SHALL drop coin to 0 immediately; no pulse resumes after release.

Verification
REQ-025 Toggle with ps2_key[15:0]=E075, rotate=0 -> p1_dir=1000 two clocks later; toggle with [23:0]=E0F075 -> p1_dir=0000.
REQ-026 joystick_0=0x0008 (U), rotate=1 -> p1_dir=0001 (right) after 1 clock; rotate=2 -> 0010.
REQ-027 joystick_0 bit8 held 5*COIN_CYCLES -> coin1 exactly one pulse of COIN_CYCLES clocks; second press during LOCKOUT -> no pulse.
REQ-028 Key U and joystick D on P1 together -> p1_dir up/down both 0; release D -> 1000.
REQ-029 autofire_en=1, btn0 held, AUTOFIRE_DIV=4 -> p1_btn[0] alternates 4 high/4 low; autofire_en=0 -> steady 1.
REQ-030 ps2_key[64]=1 at reset release with code 005 -> start stays 00; NPLAYERS=1 with joystick_1 U -> p1_dir=1000, p2_dir=0000.
